// File: rtl/validator_pkg.sv
// validator_pkg
// Shared encodings for the per-piece move validators: mode codes,
// FSM state encoding, per-axis step direction and the empty-square code.
package validator_pkg;

    localparam logic [1:0] MODE_ROOK   = 2'd0;
    localparam logic [1:0] MODE_BISHOP = 2'd1;
    localparam logic [1:0] MODE_QUEEN  = 2'd2;

    localparam int EMPTY_SQUARE = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        DIR_ZERO = 2'd0,
        DIR_POS  = 2'd1,
        DIR_NEG  = 2'd2
    } dir_e;

endpackage

// File: rtl/slide_geometry.sv
// slide_geometry
// Purely combinational move geometry: from origin, destination and mode it
// produces legality, per-axis step direction and the path length
// (steps = max(dx, dy)). Shared with the king and knight distance checks.
import validator_pkg::*;

module slide_geometry #(
    parameter int COORD_W = 3
) (
    input  logic [COORD_W-1:0] i_piece_x,
    input  logic [COORD_W-1:0] i_piece_y,
    input  logic [COORD_W-1:0] i_move_x,
    input  logic [COORD_W-1:0] i_move_y,
    input  logic [1:0]         i_mode,
    output logic               o_legal,
    output dir_e               o_dir_x,
    output dir_e               o_dir_y,
    output logic [COORD_W-1:0] o_steps
);

    logic [COORD_W-1:0] w_dx;
    logic [COORD_W-1:0] w_dy;
    logic               w_rookOk;
    logic               w_bishopOk;

    // Absolute distance and step direction along each axis, never wrapping
    always_comb begin
        w_dx    = '0;
        w_dy    = '0;
        o_dir_x = DIR_ZERO;
        o_dir_y = DIR_ZERO;
        if (i_move_x > i_piece_x) begin
            w_dx    = i_move_x - i_piece_x;
            o_dir_x = DIR_POS;
        end else if (i_move_x < i_piece_x) begin
            w_dx    = i_piece_x - i_move_x;
            o_dir_x = DIR_NEG;
        end
        if (i_move_y > i_piece_y) begin
            w_dy    = i_move_y - i_piece_y;
            o_dir_y = DIR_POS;
        end else if (i_move_y < i_piece_y) begin
            w_dy    = i_piece_y - i_move_y;
            o_dir_y = DIR_NEG;
        end
    end

    // Line shape tests, mode selection and path length
    always_comb begin
        w_rookOk   = (w_dx == '0) != (w_dy == '0);
        w_bishopOk = (w_dx == w_dy) && (w_dx != '0);
        o_steps    = (w_dx > w_dy) ? w_dx : w_dy;
        o_legal    = 1'b0;
        case (i_mode)
            MODE_ROOK:   o_legal = w_rookOk;
            MODE_BISHOP: o_legal = w_bishopOk;
            MODE_QUEEN:  o_legal = w_rookOk || w_bishopOk;
            default:     o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/validator_slider.sv
// validator_slider
// Path validator for rook, bishop and queen. Checks move geometry, then walks
// every intermediate square through the board-memory read port (one-cycle
// read latency) and stops at the first occupied square.
// Optional feature macro: VALIDATOR_SLIDER_BLOCKER_EN reports the first
// blocking square (or the destination) on blocker_x/y; otherwise they are 0.
import validator_pkg::*;

module validator_slider #(
    parameter int COORD_W = 3,
    parameter int PIECE_W = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start_validation,
    input  logic [1:0]           i_mode,
    input  logic [COORD_W-1:0]   i_piece_x,
    input  logic [COORD_W-1:0]   i_piece_y,
    input  logic [COORD_W-1:0]   i_move_x,
    input  logic [COORD_W-1:0]   i_move_y,
    input  logic [PIECE_W-1:0]   i_piece_read,
    output logic [2*COORD_W-1:0] o_address_validator,
    output logic                 o_busy,
    output logic                 o_slider_complete,
    output logic                 o_slider_valid,
    output logic [COORD_W-1:0]   o_blocker_x,
    output logic [COORD_W-1:0]   o_blocker_y
);

    state_e             r_state;
    state_e             w_nextState;
    logic [1:0]         r_mode;
    logic [COORD_W-1:0] r_pieceX;
    logic [COORD_W-1:0] r_pieceY;
    logic [COORD_W-1:0] r_moveX;
    logic [COORD_W-1:0] r_moveY;
    logic [COORD_W-1:0] r_k;
    logic               r_valid;

    logic               w_legal;
    dir_e               w_dirX;
    dir_e               w_dirY;
    logic [COORD_W-1:0] w_steps;
    logic [COORD_W-1:0] w_scanX;
    logic [COORD_W-1:0] w_scanY;
    logic               w_accept;
    logic               w_hit;
    logic               w_last;
    logic               w_finishCheck;
    logic               w_finishScan;

    // Square k along one axis; a legal path always stays on the board,
    // so plain COORD_W-bit arithmetic never wraps.
    function automatic logic [COORD_W-1:0] stepCoord(
        input logic [COORD_W-1:0] origin,
        input dir_e               dir,
        input logic [COORD_W-1:0] k
    );
        logic [COORD_W-1:0] result;
        case (dir)
            DIR_POS: result = origin + k;
            DIR_NEG: result = origin - k;
            default: result = origin;
        endcase
        return result;
    endfunction

    slide_geometry #(.COORD_W(COORD_W)) u_geometry (
        .i_piece_x (r_pieceX),
        .i_piece_y (r_pieceY),
        .i_move_x  (r_moveX),
        .i_move_y  (r_moveY),
        .i_mode    (r_mode),
        .o_legal   (w_legal),
        .o_dir_x   (w_dirX),
        .o_dir_y   (w_dirY),
        .o_steps   (w_steps)
    );

    assign w_accept      = (r_state == ST_IDLE) && i_start_validation;
    assign w_scanX       = stepCoord(r_pieceX, w_dirX, r_k);
    assign w_scanY       = stepCoord(r_pieceY, w_dirY, r_k);
    assign w_hit         = (r_k != COORD_W'(1)) && (i_piece_read != PIECE_W'(EMPTY_SQUARE));
    assign w_last        = (r_k == w_steps);
    assign w_finishCheck = (r_state == ST_CHECK) && (w_nextState == ST_DONE);
    assign w_finishScan  = (r_state == ST_SCAN) && (w_nextState == ST_DONE);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_nextState;
    end

    // Next-state: the first SCAN cycle only issues an address, later ones also compare
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:  if (i_start_validation) w_nextState = ST_CHECK;
            ST_CHECK: w_nextState = (!w_legal || (w_steps <= COORD_W'(1))) ? ST_DONE : ST_SCAN;
            ST_SCAN:  if (w_hit || w_last) w_nextState = ST_DONE;
            default:  w_nextState = ST_IDLE;
        endcase
    end

    // Capture the request so later input changes cannot disturb it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode   <= '0;
            r_pieceX <= '0;
            r_pieceY <= '0;
            r_moveX  <= '0;
            r_moveY  <= '0;
        end else if (w_accept) begin
            r_mode   <= i_mode;
            r_pieceX <= i_piece_x;
            r_pieceY <= i_piece_y;
            r_moveX  <= i_move_x;
            r_moveY  <= i_move_y;
        end
    end

    // Path index k: 1 on entering SCAN, advancing each scan cycle, 0 otherwise
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                     r_k <= '0;
        else if (w_nextState == ST_SCAN)  r_k <= (r_state == ST_SCAN) ? r_k + COORD_W'(1) : COORD_W'(1);
        else                              r_k <= '0;
    end

    // Result flag, loaded on the edge that enters DONE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)           r_valid <= 1'b0;
        else if (w_accept)      r_valid <= 1'b0;
        else if (w_finishCheck) r_valid <= w_legal;
        else if (w_finishScan)  r_valid <= !w_hit;
    end

`ifdef VALIDATOR_SLIDER_BLOCKER_EN
    logic [COORD_W-1:0] r_blockerX;
    logic [COORD_W-1:0] r_blockerY;
    logic [COORD_W-1:0] w_prevX;
    logic [COORD_W-1:0] w_prevY;

    assign w_prevX = stepCoord(r_pieceX, w_dirX, r_k - COORD_W'(1));
    assign w_prevY = stepCoord(r_pieceY, w_dirY, r_k - COORD_W'(1));

    // Blocking square on a blocked result, destination otherwise
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_blockerX <= '0;
            r_blockerY <= '0;
        end else if (w_finishScan && w_hit) begin
            r_blockerX <= w_prevX;
            r_blockerY <= w_prevY;
        end else if (w_finishCheck || w_finishScan) begin
            r_blockerX <= r_moveX;
            r_blockerY <= r_moveY;
        end
    end

    assign o_blocker_x = r_blockerX;
    assign o_blocker_y = r_blockerY;
`else
    assign o_blocker_x = '0;
    assign o_blocker_y = '0;
`endif

    // Only intermediate squares are addressed; the destination is never read
    assign o_address_validator = ((r_state == ST_SCAN) && (r_k < w_steps)) ?
                                 {w_scanX, w_scanY} : {r_pieceX, r_pieceY};
    assign o_busy              = (r_state == ST_CHECK) || (r_state == ST_SCAN);
    assign o_slider_complete   = (r_state == ST_DONE);
    assign o_slider_valid      = r_valid;

endmodule

// File: doc/validator_slider.md
# validator_slider

Parametrised path validator for sliding pieces (rook, bishop, queen) on a 2^COORD_W × 2^COORD_W board. It checks move geometry for the selected mode and then scans every intermediate square through the board-memory read port, stopping at the first blocker. It sits beside the other per-piece validators under the move-validation controller, which arbitrates board-memory access and grants it for the whole validation.

## Interface
- COORD_W, 3, coordinate width; board side = 2^COORD_W
- PIECE_W, 4, width of a board-memory square code; code 0 = empty
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start_validation  in  1  one-cycle request; sampled only in IDLE
- mode  in  2  0 = ROOK, 1 = BISHOP, 2 = QUEEN, 3 = reserved (always illegal)
- piece_x, piece_y  in  COORD_W each  origin square
- move_x, move_y  in  COORD_W each  destination square
- piece_read  in  PIECE_W  board-memory data; valid one cycle after address_validator
- address_validator  out  2*COORD_W  {x, y} read address
- busy  out  1  high from the cycle after start is accepted until done
- slider_complete  out  1  one-cycle done pulse
- slider_valid  out  1  result; held until the next accepted start
- blocker_x, blocker_y  out  COORD_W each  first blocking square (see Configuration)

## Operation
- On accept, capture origin, destination and mode into registers. Later input changes are ignored.
- Geometry: dx = |move_x − piece_x|, dy = |move_y − piece_y|, each COORD_W bits, no wrap.
  - ROOK is legal iff exactly one of dx, dy is zero.
  - BISHOP is legal iff dx == dy != 0.
  - QUEEN is legal iff ROOK or BISHOP is legal.
- Step direction per axis is −1, 0 or +1. Path length is steps = max(dx, dy). Intermediate squares are n = steps − 1.
- Square k (1..n) is origin + k·dir. Compute it in COORD_W+1 bits; the result is always on the board.
- The destination square is never read. Capture and colour rules belong to the controller.
- Square k is blocked iff its piece_read ≠ 0. Scanning stops at the first blocker.
- slider_valid = legal geometry AND no blocker.
- FSM:
  - IDLE: on start → CHECK.
  - CHECK: illegal or n == 0 → DONE; otherwise → SCAN with k = 1.
  - SCAN: each cycle issues address k and compares the data for k−1. A blocker or the last compare → DONE.
  - DONE: pulses slider_complete and loads slider_valid → IDLE.
- A start asserted while busy is ignored. address_validator outputs the origin whenever not in SCAN.

## Timing
- Let T be the cycle in which start is sampled.
- Illegal geometry or adjacent legal move: done at T+2.
- All n intermediate squares clear: done at T+3+n.
- Blocker at square j: done at T+3+j.
- slider_valid and blocker_* update on the same edge that raises slider_complete.
- Reset values: state IDLE; busy 0; slider_complete 0; slider_valid 0; address_validator 0; blocker_x/y 0; k 0.
- Reset asserted mid-validation aborts immediately. No done pulse is produced.
- Back-to-back operation: start may be asserted in the cycle after done. The FSM is in IDLE then and accepts it.

## Configuration
- VALIDATOR_SLIDER_BLOCKER_EN defined:
  - On a blocked result, blocker_x/y are loaded with the first blocking square.
  - On a valid or illegal-geometry result, they are loaded with the destination.
- Undefined: blocker_x/y are tied to 0 and their logic is removed. All other behaviour is identical.

## Structure
- Shared package validator_pkg holds:
  - mode encoding constants (MODE_ROOK, MODE_BISHOP, MODE_QUEEN)
  - the FSM state encoding
  - EMPTY_SQUARE = 0
- Sub-module slide_geometry is combinational. It maps origin, destination and mode to legal, dir_x, dir_y and steps. It is reused by the future king and knight validators' distance checks.

## Test plan
- ROOK (0,0)→(0,5), board empty → slider_valid=1, done at T+7, addresses (0,1)..(0,4) issued.
- ROOK (0,0)→(0,5), square (0,2) = 4'h3 → slider_valid=0, done at T+5, blocker=(0,2) with the macro defined.
- BISHOP (2,2)→(5,5), empty → valid=1; (2,2)→(5,4) → valid=0, done at T+2, no SCAN addresses.
- QUEEN (7,7)→(3,3) and (7,0)→(7,1) empty → both valid=1; the adjacent case completes at T+2. mode=3 → valid=0.
- Zero move (4,4)→(4,4) in each mode → valid=0 at T+2. A second start during a scan is ignored.
- reset low during SCAN → all outputs return to 0 asynchronously, no done pulse. A new start after release completes normally.
